// File: rtl/ct_ebiu_ncrt_pkg.sv
// Shared definitions for the EBIU non-cacheable read table: entry state
// encoding, bus id prefix, line-address slice and PIU select decode.
package ct_ebiu_ncrt_pkg;

  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_WDEP   = 2'b01,
    ST_RDY    = 2'b10,
    ST_WAIT_R = 2'b11
  } ncrt_state_e;

  localparam logic [5:0] BUS_ID_PFX = 6'b111101;

  // 64B line slice compared by the NC write table when building depd vectors
  localparam int LINE_MSB = 13;
  localparam int LINE_LSB = 6;

  function automatic logic [3:0] piu_sel_decode(input logic [2:0] mid);
    if (mid[2]) return 4'b1111;
    return 4'b0001 << mid[1:0];
  endfunction

endpackage

// File: rtl/ct_ebiu_ncrt_entry.sv
// One read-table entry: holds the request, waits out NC write dependencies,
// then counts R beats until the last one frees it.
module ct_ebiu_ncrt_entry
  import ct_ebiu_ncrt_pkg::*;
#(
  parameter int NCWT_ENTRIES = 8,
  parameter int ADDRW        = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc,
  input  logic [7:0]              alloc_id,
  input  logic [ADDRW-1:0]        alloc_addr,
  input  logic [1:0]              alloc_len,
  input  logic [NCWT_ENTRIES-1:0] alloc_depd,
  input  logic [NCWT_ENTRIES-1:0] ncwt_vld_vec,
  input  logic                    issue,
  input  logic                    beat,
  input  logic                    rlast,
  output ncrt_state_e             state,
  output logic [7:0]              id,
  output logic [ADDRW-1:0]        addr,
  output logic [1:0]              len,
  output logic [1:0]              beat_cnt
);

  logic [NCWT_ENTRIES-1:0] depd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FREE;
      id       <= '0;
      addr     <= '0;
      len      <= '0;
      beat_cnt <= '0;
      depd     <= '0;
    end else begin
      case (state)
        ST_FREE: begin
          if (alloc) begin
            id    <= alloc_id;
            addr  <= alloc_addr;
            len   <= alloc_len;
            depd  <= alloc_depd;
            state <= (|alloc_depd) ? ST_WDEP : ST_RDY;
          end
        end
        ST_WDEP: begin
          // Retired writes drop out of depd; the move to RDY trails by a cycle.
          depd <= depd & ncwt_vld_vec;
          if (depd == '0) state <= ST_RDY;
        end
        ST_RDY: begin
          if (issue) begin
            state    <= ST_WAIT_R;
            beat_cnt <= '0;
          end
        end
        ST_WAIT_R: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 2'd1;
            if (rlast) state <= ST_FREE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ct_ebiu_ncrt.sv
// Non-cacheable read table: allocates NC reads, stalls them behind NC writes
// to the same line, issues AR in allocation order and routes R back to PIU.
module ct_ebiu_ncrt
  import ct_ebiu_ncrt_pkg::*;
#(
  parameter int ENTRIES      = 4,
  parameter int NCWT_ENTRIES = 8,
  parameter int ADDRW        = 40,
  parameter int IDXW         = $clog2(ENTRIES),
  parameter logic [7-IDXW:0] BUS_ID_PFX = ct_ebiu_ncrt_pkg::BUS_ID_PFX
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,
  input  logic                    ncq_rd_create_vld,
  output logic                    ncq_rd_create_rdy,
  input  logic [7:0]              ncq_rd_id,
  input  logic [ADDRW-1:0]        ncq_rd_addr,
  input  logic [1:0]              ncq_rd_len,
  input  logic [NCWT_ENTRIES-1:0] ncwt_depd_vec,
  input  logic [NCWT_ENTRIES-1:0] ncwt_vld_vec,
  output logic                    ebiu_arvalid,
  input  logic                    ebiu_arready,
  output logic [7:0]              ebiu_arid,
  output logic [ADDRW-1:0]        ebiu_araddr,
  output logic [1:0]              ebiu_arlen,
  input  logic                    ebiu_rvalid,
  output logic                    ebiu_rready,
  input  logic [7:0]              ebiu_rid,
  input  logic [1:0]              ebiu_rresp,
  input  logic                    ebiu_rlast,
  output logic                    piu_rvalid,
  input  logic                    piu_rready,
  output logic [7:0]              piu_rid,
  output logic [1:0]              piu_rresp,
  output logic                    piu_rlast,
  output logic [3:0]              ncrt_piu_sel,
  output logic                    ncrt_empty,
  output logic                    ncrt_prot_err
);

  ncrt_state_e      st     [ENTRIES];
  logic [7:0]       e_id   [ENTRIES];
  logic [ADDRW-1:0] e_addr [ENTRIES];
  logic [1:0]       e_len  [ENTRIES];
  logic [1:0]       e_beat [ENTRIES];

  logic [ENTRIES-1:0]      free_vec, alloc_vec, issue_vec, beat_vec;
  logic [IDXW-1:0]         alloc_idx, head, r_idx;
  logic [IDXW-1:0]         fifo [ENTRIES];
  logic [IDXW-1:0]         wr_ptr, rd_ptr;
  logic [IDXW:0]           fifo_cnt;
  logic [NCWT_ENTRIES-1:0] new_depd;
  logic                    create, ar_hs, hit, hit_hs;

  always_comb begin
    free_vec  = '0;
    alloc_idx = '0;
    for (int i = 0; i < ENTRIES; i++) free_vec[i] = (st[i] == ST_FREE);
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IDXW'(i);
    end
  end

  assign ncq_rd_create_rdy = |free_vec;
  assign ncrt_empty        = &free_vec;
  assign create            = ncq_rd_create_vld & ncq_rd_create_rdy;
  assign new_depd          = ncwt_depd_vec & ncwt_vld_vec;

  // All channels use valid/ready: a transfer happens on a cycle where both are
  // high; arvalid holds with stable fields until accepted.
  assign head         = fifo[rd_ptr];
  assign ebiu_arvalid = (fifo_cnt != '0) && (st[head] == ST_RDY);
  assign ebiu_arid    = {BUS_ID_PFX, head};
  assign ebiu_araddr  = e_addr[head];
  assign ebiu_arlen   = e_len[head];
  assign ar_hs        = ebiu_arvalid & ebiu_arready;

  assign r_idx        = ebiu_rid[IDXW-1:0];
  assign hit          = (st[r_idx] == ST_WAIT_R) && (ebiu_rid[7:IDXW] == BUS_ID_PFX);
  assign hit_hs       = hit & ebiu_rvalid & piu_rready;
  assign piu_rvalid   = hit & ebiu_rvalid;
  // Unknown ids are drained so a stray beat cannot wedge the R channel.
  assign ebiu_rready  = ~cpurst & (hit ? piu_rready : 1'b1);
  assign piu_rid      = hit ? e_id[r_idx] : 8'h00;
  assign piu_rresp    = ebiu_rresp;
  assign piu_rlast    = ebiu_rlast;
  assign ncrt_piu_sel = piu_sel_decode(piu_rid[7:5]);

  always_comb begin
    alloc_vec = '0;
    issue_vec = '0;
    beat_vec  = '0;
    alloc_vec[alloc_idx] = create;
    issue_vec[head]      = ar_hs;
    beat_vec[r_idx]      = hit_hs;
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    ct_ebiu_ncrt_entry #(
      .NCWT_ENTRIES(NCWT_ENTRIES),
      .ADDRW       (ADDRW)
    ) u_entry (
      .clk         (forever_cpuclk),
      .rst         (cpurst),
      .alloc       (alloc_vec[g]),
      .alloc_id    (ncq_rd_id),
      .alloc_addr  (ncq_rd_addr),
      .alloc_len   (ncq_rd_len),
      .alloc_depd  (new_depd),
      .ncwt_vld_vec(ncwt_vld_vec),
      .issue       (issue_vec[g]),
      .beat        (beat_vec[g]),
      .rlast       (ebiu_rlast),
      .state       (st[g]),
      .id          (e_id[g]),
      .addr        (e_addr[g]),
      .len         (e_len[g]),
      .beat_cnt    (e_beat[g])
    );
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) fifo[i] <= '0;
    end else begin
      if (create) begin
        fifo[wr_ptr] <= alloc_idx;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (ar_hs) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (IDXW+1)'(create) - (IDXW+1)'(ar_hs);
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      ncrt_prot_err <= 1'b0;
    end else if ((ebiu_rvalid && !hit) ||
                 (hit_hs && (ebiu_rlast != (e_beat[r_idx] == e_len[r_idx])))) begin
      ncrt_prot_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ct_ebiu_ncrt.sv
// Bench for the NC read table: directed scenarios plus random traffic, all
// checked against a request-level model of the table.
module tb_ct_ebiu_ncrt;

  localparam logic [5:0] PFX = 6'b111101;

  logic        clk, rst;
  logic        c_vld, c_rdy;
  logic [7:0]  c_id;
  logic [39:0] c_addr;
  logic [1:0]  c_len;
  logic [7:0]  depd_vec, vld_vec;
  logic        arvalid, arready;
  logic [7:0]  arid;
  logic [39:0] araddr;
  logic [1:0]  arlen;
  logic        rvalid, rready;
  logic [7:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        p_rvalid, p_rready;
  logic [7:0]  p_rid;
  logic [1:0]  p_rresp;
  logic        p_rlast;
  logic [3:0]  p_sel;
  logic        empty, prot_err;

  int n_vec = 0;
  int n_err = 0;

  // request-level model
  bit          m_busy[4], m_ready[4], m_issued[4];
  logic [7:0]  m_dep[4], m_id[4];
  logic [39:0] m_addr[4];
  int          m_len[4], m_beats[4];
  int          ord_q[$];
  bit          m_err;

  ct_ebiu_ncrt dut (
    .forever_cpuclk(clk), .cpurst(rst),
    .ncq_rd_create_vld(c_vld), .ncq_rd_create_rdy(c_rdy), .ncq_rd_id(c_id),
    .ncq_rd_addr(c_addr), .ncq_rd_len(c_len),
    .ncwt_depd_vec(depd_vec), .ncwt_vld_vec(vld_vec),
    .ebiu_arvalid(arvalid), .ebiu_arready(arready), .ebiu_arid(arid),
    .ebiu_araddr(araddr), .ebiu_arlen(arlen),
    .ebiu_rvalid(rvalid), .ebiu_rready(rready), .ebiu_rid(rid),
    .ebiu_rresp(rresp), .ebiu_rlast(rlast),
    .piu_rvalid(p_rvalid), .piu_rready(p_rready), .piu_rid(p_rid),
    .piu_rresp(p_rresp), .piu_rlast(p_rlast), .ncrt_piu_sel(p_sel),
    .ncrt_empty(empty), .ncrt_prot_err(prot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_sel(input logic [2:0] mid);
    if (mid >= 3'd4) return 4'hf;
    return 4'(1 << mid);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 0; m_ready[i] = 0; m_issued[i] = 0; m_dep[i] = 0;
      m_id[i] = 0; m_addr[i] = 0; m_len[i] = 0; m_beats[i] = 0;
    end
    ord_q.delete();
    m_err = 0;
  endtask

  task automatic check_outputs();
    bit any_free = 0, all_free = 1, exp_arv = 0, r_hit;
    int head = 0, r_idx;
    for (int i = 0; i < 4; i++) begin
      if (!m_busy[i]) any_free = 1; else all_free = 0;
    end
    if (ord_q.size() > 0) begin
      head = ord_q[0];
      exp_arv = m_ready[head];
    end
    r_idx = int'(rid[1:0]);
    r_hit = m_busy[r_idx] && m_issued[r_idx] && (rid[7:2] == PFX);
    check("create_rdy", 64'(c_rdy), 64'(any_free));
    check("empty", 64'(empty), 64'(all_free));
    check("arvalid", 64'(arvalid), 64'(exp_arv));
    if (exp_arv) begin
      check("arid", 64'(arid), 64'({PFX, 2'(head)}));
      check("araddr", 64'(araddr), 64'(m_addr[head]));
      check("arlen", 64'(arlen), 64'(m_len[head]));
    end
    check("rready", 64'(rready), rst ? 64'd0 : (r_hit ? 64'(p_rready) : 64'd1));
    check("piu_rvalid", 64'(p_rvalid), 64'(r_hit && rvalid));
    if (r_hit && rvalid) begin
      check("piu_rid", 64'(p_rid), 64'(m_id[r_idx]));
      check("piu_rresp", 64'(p_rresp), 64'(rresp));
      check("piu_rlast", 64'(p_rlast), 64'(rlast));
      check("piu_sel", 64'(p_sel), 64'(exp_sel(m_id[r_idx][7:5])));
    end
    check("prot_err", 64'(prot_err), 64'(m_err));
  endtask

  task automatic model_update();
    bit do_create = 0, do_ar = 0, r_hit;
    int a_idx = 0, h_idx, r_idx;
    for (int i = 3; i >= 0; i--) begin
      if (!m_busy[i]) begin a_idx = i; do_create = c_vld; end
    end
    if (ord_q.size() > 0) do_ar = m_ready[ord_q[0]] && arready;
    r_idx = int'(rid[1:0]);
    r_hit = m_busy[r_idx] && m_issued[r_idx] && (rid[7:2] == PFX);
    for (int i = 0; i < 4; i++) begin
      if (m_busy[i] && !m_ready[i]) begin
        if (m_dep[i] == 8'h00) m_ready[i] = 1;
        else m_dep[i] = m_dep[i] & vld_vec;
      end
    end
    if (do_ar) begin
      h_idx = ord_q.pop_front();
      m_issued[h_idx] = 1;
      m_beats[h_idx] = 0;
    end
    if (rvalid && r_hit && p_rready) begin
      if (rlast != (m_beats[r_idx] == m_len[r_idx])) m_err = 1;
      m_beats[r_idx] = (m_beats[r_idx] + 1) % 4;
      if (rlast) m_busy[r_idx] = 0;
    end else if (rvalid && !r_hit) begin
      m_err = 1;
    end
    if (do_create) begin
      m_busy[a_idx] = 1; m_issued[a_idx] = 0;
      m_id[a_idx] = c_id; m_addr[a_idx] = c_addr; m_len[a_idx] = int'(c_len);
      m_dep[a_idx] = depd_vec & vld_vec;
      m_ready[a_idx] = (m_dep[a_idx] == 8'h00);
      ord_q.push_back(a_idx);
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    c_vld = 0; c_id = 0; c_addr = 0; c_len = 0; depd_vec = 0; vld_vec = 0;
    arready = 0; rvalid = 0; rid = 0; rresp = 0; rlast = 0; p_rready = 1;
  endtask

  task automatic create(input logic [7:0] id, input logic [39:0] addr, input logic [1:0] len);
    c_vld = 1; c_id = id; c_addr = addr; c_len = len;
  endtask

  task automatic send_r(input int idx, input logic last);
    rvalid = 1; rid = {PFX, 2'(idx)}; rlast = last; rresp = 2'($urandom);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    model_reset();
    #1;
    check_outputs();
    check("rst_rready", 64'(rready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      bit busy_any = 0;
      int pick = -1;
      for (int i = 0; i < 4; i++) begin
        if (m_busy[i]) busy_any = 1;
        if (m_busy[i] && m_issued[i] && pick < 0) pick = i;
      end
      if (!busy_any) break;
      idle();
      arready = 1;
      if (pick >= 0) send_r(pick, 1'(m_beats[pick] == m_len[pick]));
      cycle();
    end
    idle();
    #1;
    check("drain_done", 64'(empty), 64'd1);
  endtask

  task automatic rand_inputs(input bit err_en);
    int outs[$];
    int k;
    c_vld    = 1'($urandom_range(0, 2) == 0);
    c_id     = 8'($urandom);
    c_addr   = {8'($urandom), 32'($urandom)};
    c_len    = 2'($urandom);
    depd_vec = ($urandom_range(0, 1) == 0) ? 8'($urandom & $urandom) : 8'h00;
    if ($urandom_range(0, 7) == 0) vld_vec = 8'($urandom);
    else vld_vec = vld_vec & 8'($urandom | $urandom);
    arready  = 1'($urandom_range(0, 1));
    p_rready = 1'($urandom_range(0, 3) != 0);
    rresp    = 2'($urandom);
    rvalid = 0; rid = 0; rlast = 0;
    for (int i = 0; i < 4; i++) if (m_busy[i] && m_issued[i]) outs.push_back(i);
    if (outs.size() > 0 && $urandom_range(0, 2) != 0) begin
      k = outs[$urandom_range(0, outs.size() - 1)];
      send_r(k, 1'(m_beats[k] == m_len[k]));
    end
    if (err_en && $urandom_range(0, 15) == 0) begin
      rvalid = 1; rid = 8'($urandom); rlast = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    do_reset();

    // single read, no dependency
    create(8'h23, 40'h80, 2'd0);
    cycle();
    idle(); arready = 1; #1;
    check("t1_arvalid", 64'(arvalid), 64'd1);
    check("t1_arid", 64'(arid), 64'hF4);
    cycle();
    idle(); send_r(0, 1'b1); #1;
    check("t1_piu_rvalid", 64'(p_rvalid), 64'd1);
    check("t1_piu_rid", 64'(p_rid), 64'h23);
    cycle();
    idle(); #1;
    check("t1_empty", 64'(empty), 64'd1);
    check("t1_piu_rvalid_drop", 64'(p_rvalid), 64'd0);
    cycle();

    // write dependency holds the read until the write retires
    vld_vec = 8'h04; depd_vec = 8'h04; create(8'h41, 40'h1c0, 2'd1);
    cycle();
    c_vld = 0; depd_vec = 0; arready = 1;
    cycle(); cycle();
    vld_vec = 8'h00;
    cycle(); cycle();
    #1;
    check("t2_arvalid", 64'(arvalid), 64'd1);
    drain();

    // older WDEP entry blocks a younger RDY entry
    vld_vec = 8'h10; depd_vec = 8'h10; create(8'h51, 40'h200, 2'd0);
    cycle();
    depd_vec = 8'h00; create(8'h52, 40'h240, 2'd0);
    cycle();
    c_vld = 0; arready = 1;
    cycle(); cycle();
    #1;
    check("t3_blocked", 64'(arvalid), 64'd0);
    vld_vec = 8'h00;
    cycle(); cycle();
    #1;
    check("t3_arid0", 64'(arid), 64'hF4);
    cycle();
    #1;
    check("t3_arvalid1", 64'(arvalid), 64'd1);
    check("t3_arid1", 64'(arid), 64'hF5);
    cycle();
    drain();

    // full table, retire idx 2, reallocate idx 2
    for (int i = 0; i < 4; i++) begin
      create(8'(8'h60 + i), 40'(40'h1000 + 64 * i), 2'd0);
      cycle();
    end
    idle(); #1;
    check("t4_full_rdy", 64'(c_rdy), 64'd0);
    arready = 1;
    for (int i = 0; i < 4; i++) cycle();
    idle(); send_r(2, 1'b1);
    cycle();
    idle(); #1;
    check("t4_rdy_back", 64'(c_rdy), 64'd1);
    create(8'h77, 40'h3000, 2'd0);
    cycle();
    idle(); #1;
    check("t4_realloc_arid", 64'(arid), 64'hF6);
    drain();

    // out-of-order R with PIU backpressure
    create(8'h81, 40'h4000, 2'd1); cycle();
    create(8'hA2, 40'h4040, 2'd1); cycle();
    idle(); arready = 1; cycle(); cycle();
    idle(); p_rready = 0; send_r(1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_hold_rready", 64'(rready), 64'd0);
      cycle();
    end
    p_rready = 1; cycle();
    send_r(1, 1'b1); cycle();
    send_r(0, 1'b0); p_rready = 0; cycle();
    p_rready = 1; cycle();
    send_r(0, 1'b1); #1;
    check("t5_piu_rid0", 64'(p_rid), 64'h81);
    cycle();
    idle(); #1;
    check("t5_no_err", 64'(prot_err), 64'd0);
    cycle();

    // R for a FREE entry drains and flags an error
    send_r(2, 1'b1); #1;
    check("t6_free_rready", 64'(rready), 64'd1);
    check("t6_free_piu_rvalid", 64'(p_rvalid), 64'd0);
    cycle();
    idle(); #1;
    check("t6_free_err", 64'(prot_err), 64'd1);
    do_reset();

    // early rlast on a 4-beat read
    create(8'h90, 40'h5000, 2'd3); cycle();
    idle(); arready = 1; cycle();
    idle(); send_r(0, 1'b1); cycle();
    idle(); #1;
    check("t6_early_err", 64'(prot_err), 64'd1);
    check("t6_early_free", 64'(empty), 64'd1);
    do_reset();

    // reset in the middle of a burst
    create(8'h9A, 40'h6000, 2'd3); cycle();
    idle(); arready = 1; cycle();
    idle(); send_r(0, 1'b0); cycle();
    rst = 1;
    #1;
    model_reset();
    check("t6_rst_arvalid", 64'(arvalid), 64'd0);
    check("t6_rst_piu_rvalid", 64'(p_rvalid), 64'd0);
    check("t6_rst_rready", 64'(rready), 64'd0);
    check("t6_rst_err", 64'(prot_err), 64'd0);
    check("t6_rst_empty", 64'(empty), 64'd1);
    check("t6_rst_rdy", 64'(c_rdy), 64'd1);
    do_reset();

    // random traffic, protocol-clean then with injected errors
    for (int n = 0; n < 1500; n++) begin
      rand_inputs(1'b0);
      cycle();
    end
    drain();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rand_inputs(1'b1);
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
